serial_add_sequencer: RTL and testbench

Bit-serial adder controller that sits directly around the 1-bit full-adder cell. It accepts two WIDTH-bit operands with a start pulse and feeds the full adder one bit pair per clock, LSB first, with the registered carry. It captures the cell's sum and carry-out, and presents a WIDTH-bit result plus final carry with a one-cycle done pulse. The full adder stays purely combinational; this block supplies all sequencing, carry storage and result assembly.

---
 rtl/serial_add_sequencer_if.sv | 31 +++
 rtl/serial_add_sequencer.sv | 121 ++++++++++++
 tb/tb_serial_add_sequencer.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/serial_add_sequencer_if.sv
// Bundle of request/response and full-adder cell signals for serial_add_sequencer.
// The master side issues operands and hosts the combinational full-adder cell;
// the slave side is the sequencer that walks the operands bit by bit.
`timescale 1ns/1ps
interface serial_add_sequencer_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             cin_init;
  logic             fa_a;
  logic             fa_b;
  logic             fa_cin;
  logic             fa_sum;
  logic             fa_cout;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             cout_final;

  modport master (
    output start, op_a, op_b, cin_init, fa_sum, fa_cout,
    input  fa_a, fa_b, fa_cin, busy, done, result, cout_final
  );

  modport slave (
    input  start, op_a, op_b, cin_init, fa_sum, fa_cout,
    output fa_a, fa_b, fa_cin, busy, done, result, cout_final
  );
endinterface

// File: rtl/serial_add_sequencer.sv
// Bit-serial adder controller wrapped around an external 1-bit full-adder cell.
// Operands are shifted out LSB first, one bit pair per clock, with the carry held
// in a register between bits; sums are shifted in MSB-side and assembled into
// result, which is published together with the final carry and a done pulse.
`timescale 1ns/1ps
module serial_add_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  serial_add_sequencer_if.slave bus
);

  localparam int              CNT_W    = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] a_sh_reg, a_sh_next;
  logic [WIDTH-1:0] b_sh_reg, b_sh_next;
  logic [WIDTH-1:0] sum_sh_reg, sum_sh_next;
  logic [WIDTH-1:0] result_reg, result_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             carry_reg, carry_next;
  logic             cout_final_reg, cout_final_next;
  logic [WIDTH-1:0] sum_shifted;
  logic             in_shift;

  assign in_shift = (state_reg == SHIFT);

  // Sum register shifted right with the current cell sum entering at the top.
  // Written bit by bit so that WIDTH=1 degenerates cleanly to just fa_sum.
  generate
    for (genvar gi = 0; gi < WIDTH - 1; gi++) begin : g_sum_shift
      assign sum_shifted[gi] = sum_sh_reg[gi + 1];
    end
  endgenerate
  assign sum_shifted[WIDTH-1] = bus.fa_sum;

  // State and datapath registers; asynchronous reset clears everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      a_sh_reg       <= '0;
      b_sh_reg       <= '0;
      sum_sh_reg     <= '0;
      result_reg     <= '0;
      cnt_reg        <= '0;
      carry_reg      <= 1'b0;
      cout_final_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      a_sh_reg       <= a_sh_next;
      b_sh_reg       <= b_sh_next;
      sum_sh_reg     <= sum_sh_next;
      result_reg     <= result_next;
      cnt_reg        <= cnt_next;
      carry_reg      <= carry_next;
      cout_final_reg <= cout_final_next;
    end
  end

  // Next-state and datapath update: accept in IDLE, one bit per edge in SHIFT.
  always_comb begin
    state_next      = state_reg;
    a_sh_next       = a_sh_reg;
    b_sh_next       = b_sh_reg;
    sum_sh_next     = sum_sh_reg;
    result_next     = result_reg;
    cnt_next        = cnt_reg;
    carry_next      = carry_reg;
    cout_final_next = cout_final_reg;

    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          // result/cout_final keep the previous answer until this one completes.
          a_sh_next  = bus.op_a;
          b_sh_next  = bus.op_b;
          carry_next = bus.cin_init;
          cnt_next   = '0;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        a_sh_next   = a_sh_reg >> 1;
        b_sh_next   = b_sh_reg >> 1;
        sum_sh_next = sum_shifted;
        carry_next  = bus.fa_cout;
        cnt_next    = cnt_reg + CNT_ONE;
        if (cnt_reg == LAST_BIT) begin
          result_next     = sum_shifted;
          cout_final_next = bus.fa_cout;
          state_next      = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Full-adder drive is gated so the cell sees zeros whenever no bit is active.
  assign bus.fa_a       = in_shift & a_sh_reg[0];
  assign bus.fa_b       = in_shift & b_sh_reg[0];
  assign bus.fa_cin     = in_shift & carry_reg;
  assign bus.busy       = in_shift;
  assign bus.done       = (state_reg == DONE);
  assign bus.result     = result_reg;
  assign bus.cout_final = cout_final_reg;

endmodule

// File: tb/tb_serial_add_sequencer.sv
// Self-checking bench for serial_add_sequencer (WIDTH=8) with a combinational
// full-adder cell, an arithmetic reference model and directed + random stimulus.
`timescale 1ns/1ps
module tb_serial_add_sequencer;
  localparam int W = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  serial_add_sequencer_if #(.WIDTH(W)) bus ();

  serial_add_sequencer #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Full-adder cell
  assign bus.fa_sum  = bus.fa_a ^ bus.fa_b ^ bus.fa_cin;
  assign bus.fa_cout = (bus.fa_a & bus.fa_b) | (bus.fa_cin & (bus.fa_a ^ bus.fa_b));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Carry into bit k of a+b+c, from plain integer addition of the low k bits.
  function automatic logic carry_into(input logic [W-1:0] a, input logic [W-1:0] b,
                                      input logic c, input int k);
    logic [63:0] m;
    logic [63:0] s;
    m = (64'd1 << k) - 64'd1;
    s = (64'(a) & m) + (64'(b) & m) + 64'(c);
    return s[k];
  endfunction

  // Reference model: k counts edges since acceptance; the answer is a+b+cin.
  logic           m_active = 1'b0;
  int             m_k      = 0;
  logic [W-1:0]   m_a      = '0;
  logic [W-1:0]   m_b      = '0;
  logic           m_cin    = 1'b0;
  logic [W:0]     m_sum    = '0;
  logic [W-1:0]   m_result = '0;
  logic           m_cout   = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active <= 1'b0;
      m_k      <= 0;
      m_result <= '0;
      m_cout   <= 1'b0;
    end else if (!m_active) begin
      if (bus.start) begin
        m_active <= 1'b1;
        m_k      <= 0;
        m_a      <= bus.op_a;
        m_b      <= bus.op_b;
        m_cin    <= bus.cin_init;
        m_sum    <= {1'b0, bus.op_a} + {1'b0, bus.op_b} + (W+1)'(bus.cin_init);
      end
    end else begin
      m_k <= m_k + 1;
      if (m_k + 1 == W) begin
        m_result <= m_sum[W-1:0];
        m_cout   <= m_sum[W];
      end
      if (m_k + 1 == W + 1) m_active <= 1'b0;
    end
  end

  // Per-cycle comparison of every DUT output against the model.
  always @(negedge clk) begin
    logic e_busy, e_done, e_a, e_b, e_c;
    e_busy = m_active && (m_k < W);
    e_done = m_active && (m_k == W);
    e_a = 1'b0;
    e_b = 1'b0;
    e_c = 1'b0;
    if (e_busy) begin
      e_a = m_a[m_k];
      e_b = m_b[m_k];
      e_c = carry_into(m_a, m_b, m_cin, m_k);
    end
    check("busy",       64'(bus.busy),       64'(e_busy));
    check("done",       64'(bus.done),       64'(e_done));
    check("result",     64'(bus.result),     64'(m_result));
    check("cout_final", 64'(bus.cout_final), 64'(m_cout));
    check("fa_a",       64'(bus.fa_a),       64'(e_a));
    check("fa_b",       64'(bus.fa_b),       64'(e_b));
    check("fa_cin",     64'(bus.fa_cin),     64'(e_c));
  end

  // Issue one operation from a negedge and observe W+3 cycles after the accept edge.
  // glitch>=0 pulses start with other operands in that bit cycle.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                        input int glitch, output int busy_n, output int cin_n,
                        output int done_n, output int done_at);
    bus.start    = 1'b1;
    bus.op_a     = a;
    bus.op_b     = b;
    bus.cin_init = c;
    busy_n = 0; cin_n = 0; done_n = 0; done_at = -1;
    @(negedge clk);
    for (int j = 0; j < W + 3; j++) begin
      if (bus.busy) busy_n++;
      if (bus.busy && bus.fa_cin) cin_n++;
      if (bus.done) begin
        done_n++;
        done_at = j;
      end
      if (j == glitch) begin
        bus.start    = 1'b1;
        bus.op_a     = W'($urandom) | W'(8'hFF);
        bus.op_b     = W'($urandom) | W'(8'hFF);
        bus.cin_init = 1'b0;
      end else begin
        bus.start    = 1'b0;
        bus.op_a     = W'($urandom);
        bus.op_b     = W'($urandom);
        bus.cin_init = 1'($urandom);
      end
      @(negedge clk);
    end
    bus.start = 1'b0;
    $display("op %02h + %02h + %0d -> result %02h cout %0d busy %0d done_at %0d",
             a, b, c, bus.result, bus.cout_final, busy_n, done_at);
  endtask

  task automatic directed(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic c, input int glitch,
                          input logic [W-1:0] exp_r, input logic exp_c);
    int bn, cn, dn, da;
    run_op(a, b, c, glitch, bn, cn, dn, da);
    check({name, "_result"},  64'(bus.result),     64'(exp_r));
    check({name, "_cout"},    64'(bus.cout_final), 64'(exp_c));
    check({name, "_busy_n"},  64'(bn), 64'(W));
    check({name, "_done_n"},  64'(dn), 64'd1);
    check({name, "_done_at"}, 64'(da), 64'(W));
  endtask

  initial begin
    int bn, cn, dn, da, first_done, last_done, gaps_bad;
    logic [W-1:0] ra, rb;
    logic rc;
    logic [W:0] rs;

    bus.start = 1'b0; bus.op_a = '0; bus.op_b = '0; bus.cin_init = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy",   64'(bus.busy),   64'd0);
    check("rst_done",   64'(bus.done),   64'd0);
    check("rst_result", 64'(bus.result), 64'd0);
    check("rst_fa_cin", 64'(bus.fa_cin), 64'd0);
    rst_n = 1'b1;

    directed("basic",  8'h5A, 8'h33, 1'b0, -1, 8'h8D, 1'b0);

    run_op(8'hFF, 8'h01, 1'b0, -1, bn, cn, dn, da);
    check("ripple_result",  64'(bus.result),     64'h00);
    check("ripple_cout",    64'(bus.cout_final), 64'd1);
    check("ripple_cin_cnt", 64'(cn), 64'd7);

    directed("cin1",   8'hFF, 8'h00, 1'b1, -1, 8'h00, 1'b1);
    directed("cin2",   8'h00, 8'h00, 1'b1, -1, 8'h01, 1'b0);
    directed("ignore", 8'h10, 8'h20, 1'b0, 3,  8'h30, 1'b0);

    // Reset in bit cycle 4 of AA+55
    bus.start = 1'b1; bus.op_a = 8'hAA; bus.op_b = 8'h55; bus.cin_init = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_busy",   64'(bus.busy),       64'd0);
    check("mid_rst_done",   64'(bus.done),       64'd0);
    check("mid_rst_result", 64'(bus.result),     64'd0);
    check("mid_rst_cout",   64'(bus.cout_final), 64'd0);
    check("mid_rst_fa_a",   64'(bus.fa_a),       64'd0);
    check("mid_rst_fa_b",   64'(bus.fa_b),       64'd0);
    check("mid_rst_fa_cin", 64'(bus.fa_cin),     64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    directed("after_rst", 8'h01, 8'h01, 1'b0, -1, 8'h02, 1'b0);

    // start held high for 30 cycles
    bus.start = 1'b1; bus.op_a = 8'h80; bus.op_b = 8'h80; bus.cin_init = 1'b0;
    dn = 0; first_done = -1; last_done = -1; gaps_bad = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus.done) begin
        dn++;
        if (first_done < 0) first_done = i;
        if (last_done >= 0 && i - last_done != W + 2) gaps_bad++;
        last_done = i;
      end
    end
    bus.start = 1'b0;
    check("b2b_done_n",     64'(dn),             64'd3);
    check("b2b_first_done", 64'(first_done),     64'(W));
    check("b2b_gaps_bad",   64'(gaps_bad),       64'd0);
    check("b2b_result",     64'(bus.result),     64'h00);
    check("b2b_cout",       64'(bus.cout_final), 64'd1);
    $display("op 80 + 80 + 0 held for 30 cycles -> %0d done pulses", dn);
    repeat (3) @(negedge clk);

    // Random operations, sometimes with a start pulse inside the busy window
    for (int t = 0; t < 60; t++) begin
      int g;
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom);
      g  = $urandom_range(0, 2 * W);
      if (g > W) g = -1;
      rs = {1'b0, ra} + {1'b0, rb} + (W+1)'(rc);
      run_op(ra, rb, rc, g, bn, cn, dn, da);
      check("rand_result", 64'(bus.result),     64'(rs[W-1:0]));
      check("rand_cout",   64'(bus.cout_final), 64'(rs[W]));
      check("rand_done_n", 64'(dn), 64'd1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
